slc3_control_fsm: RTL and testbench
===================================

SLC3_CONTROL_FSM -- requirements
Module: slc3_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 2: memory access wait cycles, legal range 1..15.
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run, cont  input  1 each  start and continue pushbuttons, already synchronised and active-high.
REQ-005 ir  input  16  current IR value from the datapath.
REQ-006 ben  input  1  registered branch-enable from the datapath.
REQ-007 ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led  output  1 each  register load strobes.
REQ-008 gate_pc, gate_mdr, gate_alu, gate_marmux  output  1 each  bus drivers, one-hot or all zero.
REQ-009 pcmux  output  2  00 = PC+1, 01 = bus, 10 = adder.
REQ-010 drmux  output  1  0 = R7, 1 = IR[11:9].
REQ-011 sr1mux  output  1  0 = IR[11:9], 1 = IR[8:6].
REQ-012 addr1mux  output  1  0 = SR1, 1 = PC.
REQ-013 addr2mux  output  2  00 = zero, 01 = SEXT6, 10 = SEXT9, 11 = SEXT11.
REQ-014 aluk  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A.
REQ-015 mio_en  output  1  MDR source: 0 = memory data, 1 = bus.
REQ-016 mem_rd, mem_wr  output  1 each  active-high memory strobes; never both 1.

Function
REQ-017 States SHALL be HALTED, F1, F2, F3, DEC, ADD, AND, NOT, BR, BR_T, JMP, JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3, PSE1, PSE2.
REQ-018 Outputs SHALL be a Moore decode of state only; every output is 0 in any state that does not assert it.
REQ-019 HALTED -> F1 when run=1; otherwise hold.
REQ-020 F1: gate_pc, ld_mar, ld_pc, pcmux=00; -> F2.
REQ-021 F2: mem_rd, ld_mdr, mio_en=0; held exactly MEM_WAIT cycles by a wait counter; -> F3.
REQ-022 F3: gate_mdr, ld_ir; -> DEC.
REQ-023 DEC: ld_ben; branch on ir[15:12]: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR1, 0110 LDR1, 0111 STR1, 1101 PSE1, any other opcode -> F1 (NOP).
REQ-024 ADD/AND/NOT: sr1mux=1, drmux=1, gate_alu, ld_reg, ld_cc, aluk 00/01/10 respectively; -> F1.
REQ-025 BR: -> BR_T if ben=1, else -> F1; BR_T: addr1mux=1, addr2mux=10, pcmux=10, ld_pc; -> F1.
REQ-026 JMP: sr1mux=1, addr1mux=0, addr2mux=00, pcmux=10, ld_pc; -> F1.
REQ-027 JSR1: gate_pc, drmux=0, ld_reg; JSR2: addr1mux=1, addr2mux=11, pcmux=10, ld_pc; -> F1.
REQ-028 LDR1: sr1mux=1, addr1mux=0, addr2mux=01, gate_marmux, ld_mar; LDR2 as F2 (MEM_WAIT cycles); LDR3: gate_mdr, drmux=1, ld_reg, ld_cc; -> F1.
REQ-029 STR1 as LDR1; STR2: sr1mux=0, aluk=11, gate_alu, mio_en=1, ld_mdr; STR3: mem_wr held MEM_WAIT cycles; -> F1.
REQ-030 PSE1: ld_led; hold until cont=1, -> PSE2; PSE2: hold until cont=0, -> F1.
REQ-031 Wait counter SHALL clear on entry to every memory state; no wrap.
REQ-032 run=0 in any state SHALL NOT halt execution; only reset returns to HALTED.

Reset
REQ-033 reset=1 SHALL force HALTED and counter 0 asynchronously, all outputs 0, including mid-memory-access.

Structure
REQ-034 State enum, opcode constants, ALUK/PCMUX/ADDR2MUX encodings SHALL live in package slc3_pkg, shared with the datapath.
REQ-035 Single module; wait counter inline, no sub-module.

Verification
REQ-036 Reset asserted during F2, MEM_WAIT=2 -> next cycle HALTED, mem_rd=0, all outputs 0.
REQ-037 run pulse, IR=0x1042 (ADD) -> F1,F2,F2,F3,DEC,ADD; ld_reg=1 with aluk=00 only in ADD; back in F1 at cycle 7.
REQ-038 IR=0x0E05, ben=0 -> DEC,BR,F1 with no ld_pc; ben=1 -> BR_T asserts ld_pc, pcmux=10, addr2mux=10.
REQ-039 IR=0x7241 (STR), MEM_WAIT=3 -> mem_wr high exactly 3 cycles, mem_rd never high in STR states, mio_en=1 during STR2.
REQ-040 IR=0xD000 (PAUSE), cont held 0 for 10 cycles -> stays PSE1, ld_led=1; cont 1 then 0 -> PSE2 then F1.
REQ-041 IR=0x8000 (unsupported) -> DEC then F1, no load strobe other than ld_ben.

Source files
------------

// File: rtl/slc3_pkg.sv
// ============================================================================
// Module   : slc3_pkg
// Brief    : Shared SLC-3 encodings: control states, opcodes, mux selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slc3_pkg;

  typedef logic [4:0] state_t;

  localparam logic [4:0] ST_HALTED = 5'd0;
  localparam logic [4:0] ST_F1     = 5'd1;
  localparam logic [4:0] ST_F2     = 5'd2;
  localparam logic [4:0] ST_F3     = 5'd3;
  localparam logic [4:0] ST_DEC    = 5'd4;
  localparam logic [4:0] ST_ADD    = 5'd5;
  localparam logic [4:0] ST_AND    = 5'd6;
  localparam logic [4:0] ST_NOT    = 5'd7;
  localparam logic [4:0] ST_BR     = 5'd8;
  localparam logic [4:0] ST_BR_T   = 5'd9;
  localparam logic [4:0] ST_JMP    = 5'd10;
  localparam logic [4:0] ST_JSR1   = 5'd11;
  localparam logic [4:0] ST_JSR2   = 5'd12;
  localparam logic [4:0] ST_LDR1   = 5'd13;
  localparam logic [4:0] ST_LDR2   = 5'd14;
  localparam logic [4:0] ST_LDR3   = 5'd15;
  localparam logic [4:0] ST_STR1   = 5'd16;
  localparam logic [4:0] ST_STR2   = 5'd17;
  localparam logic [4:0] ST_STR3   = 5'd18;
  localparam logic [4:0] ST_PSE1   = 5'd19;
  localparam logic [4:0] ST_PSE2   = 5'd20;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

  // States that stall on the memory wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_F2) || (s == ST_LDR2) || (s == ST_STR3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/slc3_control_fsm.sv
// ============================================================================
// Module   : slc3_control_fsm
// Brief    : SLC-3 Moore control unit with parameterised memory wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slc3_control_fsm
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cont,
  input  logic [15:0] ir,
  input  logic        ben,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_cc,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_led,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        drmux,
  output logic        sr1mux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        mem_rd,
  output logic        mem_wr
);

  localparam logic [3:0] C_WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait;
  logic       w_wait_done;
  logic [3:0] w_opcode;
  logic       w_unused_ir;

  assign w_opcode    = ir[15:12];
  assign w_unused_ir = ^ir[11:0];
  assign w_wait_done = (r_wait == C_WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HALTED: w_next = run ? ST_F1 : ST_HALTED;
      ST_F1:     w_next = ST_F2;
      ST_F2:     w_next = w_wait_done ? ST_F3 : ST_F2;
      ST_F3:     w_next = ST_DEC;
      ST_DEC: begin
        case (w_opcode)
          OP_ADD:  w_next = ST_ADD;
          OP_AND:  w_next = ST_AND;
          OP_NOT:  w_next = ST_NOT;
          OP_BR:   w_next = ST_BR;
          OP_JMP:  w_next = ST_JMP;
          OP_JSR:  w_next = ST_JSR1;
          OP_LDR:  w_next = ST_LDR1;
          OP_STR:  w_next = ST_STR1;
          OP_PSE:  w_next = ST_PSE1;
          default: w_next = ST_F1;
        endcase
      end
      ST_ADD, ST_AND, ST_NOT, ST_BR_T, ST_JMP, ST_JSR2, ST_LDR3:
                 w_next = ST_F1;
      ST_BR:     w_next = ben ? ST_BR_T : ST_F1;
      ST_JSR1:   w_next = ST_JSR2;
      ST_LDR1:   w_next = ST_LDR2;
      ST_LDR2:   w_next = w_wait_done ? ST_LDR3 : ST_LDR2;
      ST_STR1:   w_next = ST_STR2;
      ST_STR2:   w_next = ST_STR3;
      ST_STR3:   w_next = w_wait_done ? ST_F1 : ST_STR3;
      ST_PSE1:   w_next = cont ? ST_PSE2 : ST_PSE1;
      ST_PSE2:   w_next = cont ? ST_PSE2 : ST_F1;
      default:   w_next = ST_HALTED;
    endcase
  end

  // Counter runs only while a memory state holds; any state change clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HALTED;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= (is_mem_state(r_state) && (w_next == r_state)) ? r_wait + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_ben      = 1'b0;
    ld_cc       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_led      = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = PCMUX_INC;
    drmux       = 1'b0;
    sr1mux      = 1'b0;
    addr1mux    = 1'b0;
    addr2mux    = ADDR2_ZERO;
    aluk        = ALUK_ADD;
    mio_en      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (r_state)
      ST_F1: begin
        gate_pc = 1'b1;
        ld_mar  = 1'b1;
        ld_pc   = 1'b1;
        pcmux   = PCMUX_INC;
      end
      ST_F2, ST_LDR2: begin
        mem_rd = 1'b1;
        ld_mdr = 1'b1;
      end
      ST_F3: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
      end
      ST_DEC: ld_ben = 1'b1;
      ST_ADD, ST_AND, ST_NOT: begin
        sr1mux   = 1'b1;
        drmux    = 1'b1;
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        aluk     = (r_state == ST_ADD) ? ALUK_ADD :
                   (r_state == ST_AND) ? ALUK_AND : ALUK_NOT;
      end
      ST_BR_T: begin
        addr1mux = 1'b1;
        addr2mux = ADDR2_SEXT9;
        pcmux    = PCMUX_ADDER;
        ld_pc    = 1'b1;
      end
      ST_JMP: begin
        sr1mux = 1'b1;
        pcmux  = PCMUX_ADDER;
        ld_pc  = 1'b1;
      end
      ST_JSR1: begin
        gate_pc = 1'b1;
        ld_reg  = 1'b1;
      end
      ST_JSR2: begin
        addr1mux = 1'b1;
        addr2mux = ADDR2_SEXT11;
        pcmux    = PCMUX_ADDER;
        ld_pc    = 1'b1;
      end
      ST_LDR1, ST_STR1: begin
        sr1mux      = 1'b1;
        addr2mux    = ADDR2_SEXT6;
        gate_marmux = 1'b1;
        ld_mar      = 1'b1;
      end
      ST_LDR3: begin
        gate_mdr = 1'b1;
        drmux    = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      ST_STR2: begin
        aluk     = ALUK_PASS;
        gate_alu = 1'b1;
        mio_en   = 1'b1;
        ld_mdr   = 1'b1;
      end
      ST_STR3: mem_wr = 1'b1;
      ST_PSE1: ld_led = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_slc3_control_fsm.sv
// ============================================================================
// Module   : tb_slc3_control_fsm
// Brief    : Scoreboard bench for slc3_control_fsm (MEM_WAIT 2 and 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slc3_control_fsm;

  typedef enum int {
    T_HALTED, T_F1, T_F2, T_F3, T_DEC, T_ADD, T_AND, T_NOT, T_BR, T_BR_T,
    T_JMP, T_JSR1, T_JSR2, T_LDR1, T_LDR2, T_LDR3, T_STR1, T_STR2, T_STR3,
    T_PSE1, T_PSE2
  } tst_t;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mio_en, mem_rd, mem_wr;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, run_a, cont_a, ben_a;
  logic [15:0] ir_a;
  logic        rst_b, run_b, cont_b, ben_b;
  logic [15:0] ir_b;
  outs_t       act_a, act_b;

  int checks   = 0;
  int failures = 0;
  tst_t qa[$];
  tst_t qb[$];

  slc3_control_fsm #(.MEM_WAIT(2)) dut_a (
    .clk(clk), .reset(rst_a), .run(run_a), .cont(cont_a), .ir(ir_a), .ben(ben_a),
    .ld_mar(act_a.ld_mar), .ld_mdr(act_a.ld_mdr), .ld_ir(act_a.ld_ir),
    .ld_ben(act_a.ld_ben), .ld_cc(act_a.ld_cc), .ld_reg(act_a.ld_reg),
    .ld_pc(act_a.ld_pc), .ld_led(act_a.ld_led), .gate_pc(act_a.gate_pc),
    .gate_mdr(act_a.gate_mdr), .gate_alu(act_a.gate_alu),
    .gate_marmux(act_a.gate_marmux), .pcmux(act_a.pcmux), .drmux(act_a.drmux),
    .sr1mux(act_a.sr1mux), .addr1mux(act_a.addr1mux), .addr2mux(act_a.addr2mux),
    .aluk(act_a.aluk), .mio_en(act_a.mio_en), .mem_rd(act_a.mem_rd),
    .mem_wr(act_a.mem_wr)
  );

  slc3_control_fsm #(.MEM_WAIT(3)) dut_b (
    .clk(clk), .reset(rst_b), .run(run_b), .cont(cont_b), .ir(ir_b), .ben(ben_b),
    .ld_mar(act_b.ld_mar), .ld_mdr(act_b.ld_mdr), .ld_ir(act_b.ld_ir),
    .ld_ben(act_b.ld_ben), .ld_cc(act_b.ld_cc), .ld_reg(act_b.ld_reg),
    .ld_pc(act_b.ld_pc), .ld_led(act_b.ld_led), .gate_pc(act_b.gate_pc),
    .gate_mdr(act_b.gate_mdr), .gate_alu(act_b.gate_alu),
    .gate_marmux(act_b.gate_marmux), .pcmux(act_b.pcmux), .drmux(act_b.drmux),
    .sr1mux(act_b.sr1mux), .addr1mux(act_b.addr1mux), .addr2mux(act_b.addr2mux),
    .aluk(act_b.aluk), .mio_en(act_b.mio_en), .mem_rd(act_b.mem_rd),
    .mem_wr(act_b.mem_wr)
  );

  // Hand-written output table for each control state.
  function automatic outs_t exp_out(input tst_t st);
    outs_t o = '0;
    case (st)
      T_F1:   begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
      T_F2, T_LDR2: begin o.mem_rd = 1; o.ld_mdr = 1; end
      T_F3:   begin o.gate_mdr = 1; o.ld_ir = 1; end
      T_DEC:  o.ld_ben = 1;
      T_ADD:  begin o.sr1mux = 1; o.drmux = 1; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b00; end
      T_AND:  begin o.sr1mux = 1; o.drmux = 1; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b01; end
      T_NOT:  begin o.sr1mux = 1; o.drmux = 1; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b10; end
      T_BR_T: begin o.addr1mux = 1; o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
      T_JMP:  begin o.sr1mux = 1; o.pcmux = 2'b10; o.ld_pc = 1; end
      T_JSR1: begin o.gate_pc = 1; o.ld_reg = 1; end
      T_JSR2: begin o.addr1mux = 1; o.addr2mux = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1; end
      T_LDR1, T_STR1: begin o.sr1mux = 1; o.addr2mux = 2'b01; o.gate_marmux = 1; o.ld_mar = 1; end
      T_LDR3: begin o.gate_mdr = 1; o.drmux = 1; o.ld_reg = 1; o.ld_cc = 1; end
      T_STR2: begin o.aluk = 2'b11; o.gate_alu = 1; o.mio_en = 1; o.ld_mdr = 1; end
      T_STR3: o.mem_wr = 1;
      T_PSE1: o.ld_led = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    tst_t  st;
    outs_t e;
    if (qa.size() > 0) begin
      st = qa.pop_front();
      e  = exp_out(st);
      checks++;
      if (act_a !== e) begin
        failures++;
        $display("FAIL dut_a state=%s got=%h expected=%h", st.name(), act_a, e);
      end
    end
    if (qb.size() > 0) begin
      st = qb.pop_front();
      e  = exp_out(st);
      checks++;
      if (act_b !== e) begin
        failures++;
        $display("FAIL dut_b state=%s got=%h expected=%h", st.name(), act_b, e);
      end
    end
  end

  task automatic tick(input bit b, input tst_t st);
    @(posedge clk);
    #1;
    if (b) qb.push_back(st);
    else   qa.push_back(st);
  endtask

  // From F1 onward: F2 for mw cycles, F3, DEC.
  task automatic fetch(input bit b, input int mw);
    for (int i = 0; i < mw; i++) tick(b, T_F2);
    tick(b, T_F3);
    tick(b, T_DEC);
  endtask

  initial begin
    rst_a = 1; run_a = 0; cont_a = 0; ben_a = 0; ir_a = 16'h0000;
    rst_b = 1; run_b = 0; cont_b = 0; ben_b = 0; ir_b = 16'h0000;

    tick(0, T_HALTED);
    tick(0, T_HALTED);
    rst_a = 0;
    tick(0, T_HALTED);
    run_a = 1;
    tick(0, T_F1);
    run_a = 0;

    ir_a = 16'h1042;
    fetch(0, 2); tick(0, T_ADD); tick(0, T_F1);

    ir_a = 16'h0E05; ben_a = 0;
    fetch(0, 2); tick(0, T_BR); tick(0, T_F1);
    ben_a = 1;
    fetch(0, 2); tick(0, T_BR); tick(0, T_BR_T); tick(0, T_F1);
    ben_a = 0;

    ir_a = 16'h5042;
    fetch(0, 2); tick(0, T_AND); tick(0, T_F1);
    ir_a = 16'h907F;
    fetch(0, 2); tick(0, T_NOT); tick(0, T_F1);
    ir_a = 16'hC1C0;
    fetch(0, 2); tick(0, T_JMP); tick(0, T_F1);
    ir_a = 16'h4800;
    fetch(0, 2); tick(0, T_JSR1); tick(0, T_JSR2); tick(0, T_F1);
    ir_a = 16'h6241;
    fetch(0, 2); tick(0, T_LDR1); tick(0, T_LDR2); tick(0, T_LDR2);
    tick(0, T_LDR3); tick(0, T_F1);
    ir_a = 16'h8000;
    fetch(0, 2); tick(0, T_F1);

    ir_a = 16'hD000; cont_a = 0;
    fetch(0, 2);
    repeat (10) tick(0, T_PSE1);
    cont_a = 1;
    tick(0, T_PSE2); tick(0, T_PSE2);
    cont_a = 0;
    tick(0, T_F1);

    // Asynchronous reset during the second F2 cycle.
    tick(0, T_F2);
    @(posedge clk);
    #1 rst_a = 1;
    #1 qa.push_back(T_HALTED);
    tick(0, T_HALTED);
    rst_a = 0;
    tick(0, T_HALTED);

    tick(1, T_HALTED);
    rst_b = 0;
    tick(1, T_HALTED);
    run_b = 1;
    tick(1, T_F1);
    run_b = 0;
    ir_b = 16'h7241;
    fetch(1, 3);
    tick(1, T_STR1); tick(1, T_STR2);
    tick(1, T_STR3); tick(1, T_STR3); tick(1, T_STR3);
    tick(1, T_F1);
    ir_b = 16'h1042;
    fetch(1, 3); tick(1, T_ADD); tick(1, T_F1);

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() + qb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", qa.size() + qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
